cpu_branch_predictor: RTL
=========================

Name: cpu_branch_predictor

Overview:
- Replaces the purely combinational branch decision with a fetch-time predictor plus an execute-time resolver.
- Fetch side: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters supplies the predicted next PC.
- Execute side: evaluates the branch condition from ALU flags, detects mispredictions, drives the redirect PC and trains the table.
- Performance counters are included; depth and counter width are parametrised.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, ≥2. IDX_W = log2(ENTRIES).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_pc  in  32  fetch PC.
- f_pred_taken  out  1  prediction for f_pc.
- f_pred_next_pc  out  32  predicted next PC: entry target if taken, else f_pc+4.
- ex_valid  in  1  execute-stage instruction valid.
- ex_pc  in  32  execute-stage PC.
- ex_jump  in  1  unconditional jump.
- ex_branch  in  1  conditional branch.
- ex_branch_cond  in  3  000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
- ex_target  in  32  resolved target (PC-relative or ALU).
- alu_carry, alu_overflow, alu_zero, alu_neg  in  1 each  flags of rs1-rs2.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_next_pc  in  32  predicted next PC carried down the pipe.
- ex_mispredict  out  1  flush fetch/decode and redirect.
- ex_redirect_pc  out  32  correct next PC.
- ex_taken  out  1  resolved direction.
- br_count  out  CNT_W  resolved branches and jumps.
- mispred_count  out  CNT_W  mispredictions.

Behaviour:
- Storage, per entry: valid, tag = pc[31:IDX_W+2], target[31:0], is_jump, ctr[1:0]. Index = pc[IDX_W+1:2]; pc[1:0] is ignored.
- Reset (async, while rst_n=0): all valid=0, all ctr=01, both counters=0. Outputs follow from cleared state: f_pred_taken=0, f_pred_next_pc=f_pc+4, ex_mispredict=0 when ex_valid=0.
- Lookup is combinational from table state:
  - hit = valid & tag match.
  - f_pred_taken = hit & (is_jump | ctr[1]).
- Condition evaluation:
  - lt = alu_neg ^ alu_overflow.
  - LTU = !alu_carry; GEU = alu_carry.
  - Undefined codes (010, 011) evaluate to not-taken.
- Resolution, combinational, only when ex_valid:
  - ex_taken = ex_jump | (ex_branch & cond).
  - actual = ex_taken ? ex_target : ex_pc+4.
  - ex_mispredict = (actual != ex_pred_next_pc). This applies to non-branch instructions too, so a stale aliasing hit is corrected.
  - ex_redirect_pc = actual.
  - When ex_valid=0: ex_mispredict=0, ex_taken=0, ex_redirect_pc = ex_pc+4.
- Update, at the rising clock edge when ex_valid:
  - Branch/jump, taken, entry miss: allocate. valid=1, tag, target=ex_target, is_jump=ex_jump, ctr=10.
  - Branch/jump, entry hit: target=ex_target, is_jump=ex_jump. ctr increments if taken, decrements if not, saturating at 11/00.
  - Branch, not taken, miss: no allocation.
  - Non-branch, hit on ex_pc: invalidate the entry.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents (no bypass).
- br_count increments on ex_valid & (ex_branch | ex_jump). mispred_count increments on ex_mispredict. Both saturate at all-ones.
- Reset asserted mid-operation clears the table and counters immediately; no partial update survives.
- ex_jump and ex_branch both set: treated as a jump.

Test Plan:
- Reset, then f_pc=0x100 → f_pred_taken=0, f_pred_next_pc=0x104; both counters 0.
- Taken BEQ at 0x100, target 0x80, alu_zero=1, ex_pred_next_pc=0x104 → ex_mispredict=1, redirect 0x80. Next cycle f_pc=0x100 → pred taken, next 0x80, ctr=10.
- Same BEQ resolved not-taken three times → ctr 10→01→00→00; prediction flips to not-taken after the first; mispred_count counts each wrong prediction.
- BLTU with alu_carry=0 and BGE with neg=1, overflow=1 → both taken; cond 010 → not taken.
- Alias: entry at 0x100 with ENTRIES=16, then non-branch at 0x140 (same index, different tag) → no hit. Non-branch at 0x100 with stale prediction → mispredict, redirect 0x104, entry invalidated.
- Counter saturation with CNT_W=4: 20 resolved branches → br_count=15. Assert rst_n low mid-stream → table and counters cleared asynchronously.

Source files
------------

// File: rtl/cpu_branch_predictor_if.sv
// Fetch/execute bundle between the CPU pipeline (master) and the branch predictor (slave).
// Carries the fetch lookup, the execute-stage resolution inputs and the performance counters.
interface cpu_branch_predictor_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      f_pc;
    logic             f_pred_taken;
    logic [31:0]      f_pred_next_pc;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_jump;
    logic             ex_branch;
    logic [2:0]       ex_branch_cond;
    logic [31:0]      ex_target;
    logic             alu_carry;
    logic             alu_overflow;
    logic             alu_zero;
    logic             alu_neg;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_next_pc;
    logic             ex_mispredict;
    logic [31:0]      ex_redirect_pc;
    logic             ex_taken;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output f_pc, ex_valid, ex_pc, ex_jump, ex_branch, ex_branch_cond, ex_target,
               alu_carry, alu_overflow, alu_zero, alu_neg, ex_pred_taken, ex_pred_next_pc,
        input  f_pred_taken, f_pred_next_pc, ex_mispredict, ex_redirect_pc, ex_taken,
               br_count, mispred_count
    );

    modport slave (
        input  f_pc, ex_valid, ex_pc, ex_jump, ex_branch, ex_branch_cond, ex_target,
               alu_carry, alu_overflow, alu_zero, alu_neg, ex_pred_taken, ex_pred_next_pc,
        output f_pred_taken, f_pred_next_pc, ex_mispredict, ex_redirect_pc, ex_taken,
               br_count, mispred_count
    );
endinterface

// File: rtl/cpu_branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters for fetch-time prediction, plus the
// execute-time branch resolver that detects mispredictions, redirects and trains the table.
module cpu_branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jump_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [CNT_W-1:0]   br_cnt_q,  br_cnt_d;
    logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0]   f_idx_s, ex_idx_s;
    logic [TAG_W-1:0]   f_tag_s, ex_tag_s;
    logic               f_hit_s, ex_hit_s, is_br_s, cond_s;
    logic               ex_taken_s, ex_mis_s;
    logic [31:0]        ex_pc4_s, actual_s;

    logic               ent_we_s;
    logic               ent_valid_d, ent_jump_d;
    logic [TAG_W-1:0]   ent_tag_d;
    logic [31:0]        ent_target_d;
    logic [1:0]         ent_ctr_d;

    function automatic logic eval_cond(input logic [2:0] cond, input logic c, input logic v,
                                       input logic z, input logic n);
        logic r;
        case (cond)
            3'b000:  r = z;
            3'b001:  r = !z;
            3'b100:  r = n ^ v;
            3'b101:  r = !(n ^ v);
            3'b110:  r = !c;
            3'b111:  r = c;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
        logic [1:0] r;
        if (up) begin
            r = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            r = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return r;
    endfunction

    assign f_idx_s  = bp.f_pc[IDX_W+1:2];
    assign f_tag_s  = bp.f_pc[31:IDX_W+2];
    assign ex_idx_s = bp.ex_pc[IDX_W+1:2];
    assign ex_tag_s = bp.ex_pc[31:IDX_W+2];
    assign ex_pc4_s = bp.ex_pc + 32'd4;
    assign is_br_s  = bp.ex_branch | bp.ex_jump;
    assign cond_s   = eval_cond(bp.ex_branch_cond, bp.alu_carry, bp.alu_overflow,
                                bp.alu_zero, bp.alu_neg);

    // Fetch lookup: reads pre-update table contents, no bypass from the execute write.
    always_comb begin
        f_hit_s           = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
        bp.f_pred_taken   = f_hit_s && (jump_q[f_idx_s] || ctr_q[f_idx_s][1]);
        bp.f_pred_next_pc = bp.f_pred_taken ? target_q[f_idx_s] : bp.f_pc + 32'd4;
    end

    // Execute resolution: a jump wins over a simultaneous branch flag.
    always_comb begin
        ex_taken_s = 1'b0;
        actual_s   = ex_pc4_s;
        ex_mis_s   = 1'b0;
        if (bp.ex_valid) begin
            ex_taken_s = bp.ex_jump | (bp.ex_branch & cond_s);
            actual_s   = ex_taken_s ? bp.ex_target : ex_pc4_s;
            ex_mis_s   = (actual_s != bp.ex_pred_next_pc);
        end else begin
            ex_taken_s = 1'b0;
        end
        bp.ex_taken       = ex_taken_s;
        bp.ex_mispredict  = ex_mis_s;
        bp.ex_redirect_pc = actual_s;
    end

    // Training: next contents of the entry addressed by ex_pc and the counter next-states.
    always_comb begin
        ex_hit_s     = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);
        ent_we_s     = 1'b0;
        ent_valid_d  = valid_q[ex_idx_s];
        ent_jump_d   = jump_q[ex_idx_s];
        ent_tag_d    = ex_tag_s;
        ent_target_d = target_q[ex_idx_s];
        ent_ctr_d    = ctr_q[ex_idx_s];
        if (bp.ex_valid && is_br_s) begin
            if (ex_hit_s) begin
                ent_we_s     = 1'b1;
                ent_valid_d  = 1'b1;
                ent_target_d = bp.ex_target;
                ent_jump_d   = bp.ex_jump;
                ent_ctr_d    = sat_ctr(ctr_q[ex_idx_s], ex_taken_s);
            end else if (ex_taken_s) begin
                ent_we_s     = 1'b1;
                ent_valid_d  = 1'b1;
                ent_target_d = bp.ex_target;
                ent_jump_d   = bp.ex_jump;
                ent_ctr_d    = 2'b10;
            end else begin
                ent_we_s     = 1'b0;
            end
        end else if (bp.ex_valid && ex_hit_s) begin
            // Non-branch sitting on a stale entry: drop it so it stops redirecting fetch.
            ent_we_s    = 1'b1;
            ent_valid_d = 1'b0;
        end else begin
            ent_we_s    = 1'b0;
        end
        br_cnt_d  = (bp.ex_valid && is_br_s && (br_cnt_q != CNT_MAX)) ? br_cnt_q + CNT_ONE
                                                                        : br_cnt_q;
        mis_cnt_d = (ex_mis_s && (mis_cnt_q != CNT_MAX)) ? mis_cnt_q + CNT_ONE : mis_cnt_q;
    end

    // Table and performance-counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            jump_q    <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            if (ent_we_s) begin
                valid_q[ex_idx_s]  <= ent_valid_d;
                jump_q[ex_idx_s]   <= ent_jump_d;
                tag_q[ex_idx_s]    <= ent_tag_d;
                target_q[ex_idx_s] <= ent_target_d;
                ctr_q[ex_idx_s]    <= ent_ctr_d;
            end
        end
    end

    assign bp.br_count      = br_cnt_q;
    assign bp.mispred_count = mis_cnt_q;
endmodule
